// File: rtl/cmul_scheduler_if.sv
// rtl/cmul_scheduler_if.sv - request/response bundle between requesters, cmul_scheduler and the consumer
// req_conj exists only when CMUL_SCHED_CONJ_EN is defined.
interface cmul_scheduler_if #(
   parameter int WIDTH   = 32,
   parameter int NUM_REQ = 4,
   parameter int ID_W    = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1
);
   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ-1:0]       req_ready;
   logic [NUM_REQ*WIDTH-1:0] req_a;
   logic [NUM_REQ*WIDTH-1:0] req_b;
`ifdef CMUL_SCHED_CONJ_EN
   logic [NUM_REQ-1:0]       req_conj;
`endif
   logic                     rsp_valid;
   logic                     rsp_ready;
   logic [ID_W-1:0]          rsp_id;
   logic [2*WIDTH-1:0]       rsp_result;

   modport master (
`ifdef CMUL_SCHED_CONJ_EN
      output req_conj,
`endif
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_result
   );

   modport slave (
`ifdef CMUL_SCHED_CONJ_EN
      input  req_conj,
`endif
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_result
   );
endinterface

// File: rtl/cmul_scheduler.sv
// rtl/cmul_scheduler.sv - round-robin arbiter in front of a two-stage shared complex multiplier
// Define CMUL_SCHED_CONJ_EN to add per-request conjugation of operand b.
module cmul_scheduler #(
   parameter int WIDTH   = 32,
   parameter int NUM_REQ = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   cmul_scheduler_if.slave   bus
);
   localparam int ID_W = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1;
   localparam int H    = WIDTH / 2;

   logic [ID_W-1:0]    ptr;
   logic [ID_W-1:0]    gidx;
   logic [ID_W:0]      cand;
   logic [NUM_REQ-1:0] grant;
   logic               any_grant;
   logic               s1_v;
   logic               s1_adv;
   logic               s2_adv;
   logic [WIDTH-1:0]   s1_a;
   logic [WIDTH-1:0]   s1_b;
   logic [ID_W-1:0]    s1_id;
`ifdef CMUL_SCHED_CONJ_EN
   logic               s1_conj;
`endif

   logic signed [WIDTH-1:0] ar, ai, br, bi, bi_eff;
   logic signed [WIDTH-1:0] prod_re, prod_im;

   assign s2_adv = !bus.rsp_valid || bus.rsp_ready;
   assign s1_adv = !s1_v || s2_adv;

   // Scan from the far end back toward ptr so the last hit is the first in priority order.
   always_comb begin
      gidx      = '0;
      any_grant = 1'b0;
      cand      = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         cand = {1'b0, ptr} + (ID_W+1)'(k);
         if (cand >= (ID_W+1)'(NUM_REQ)) begin
            cand = cand - (ID_W+1)'(NUM_REQ);
         end
         if (bus.req_valid[cand[ID_W-1:0]]) begin
            gidx      = cand[ID_W-1:0];
            any_grant = 1'b1;
         end
      end
      grant = any_grant ? (NUM_REQ'(1) << gidx) : '0;
   end

   assign bus.req_ready = (rst_n && s1_adv) ? grant : '0;

   assign ar = {{H{s1_a[H-1]}},     s1_a[H-1:0]};
   assign ai = {{H{s1_a[WIDTH-1]}}, s1_a[WIDTH-1:H]};
   assign br = {{H{s1_b[H-1]}},     s1_b[H-1:0]};
   assign bi = {{H{s1_b[WIDTH-1]}}, s1_b[WIDTH-1:H]};

`ifdef CMUL_SCHED_CONJ_EN
   // bi is already widened, so negating -2^(H-1) cannot wrap.
   assign bi_eff = s1_conj ? -bi : bi;
`else
   assign bi_eff = bi;
`endif

   assign prod_re = ar * br - ai * bi_eff;
   assign prod_im = ar * bi_eff + ai * br;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr     <= '0;
         s1_v    <= 1'b0;
         s1_a    <= '0;
         s1_b    <= '0;
         s1_id   <= '0;
`ifdef CMUL_SCHED_CONJ_EN
         s1_conj <= 1'b0;
`endif
      end else if (s1_adv) begin
         s1_v <= any_grant;
         if (any_grant) begin
            s1_a    <= bus.req_a[gidx*WIDTH +: WIDTH];
            s1_b    <= bus.req_b[gidx*WIDTH +: WIDTH];
            s1_id   <= gidx;
`ifdef CMUL_SCHED_CONJ_EN
            s1_conj <= bus.req_conj[gidx];
`endif
            ptr     <= (gidx == ID_W'(NUM_REQ - 1)) ? '0 : gidx + ID_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.rsp_valid  <= 1'b0;
         bus.rsp_id     <= '0;
         bus.rsp_result <= '0;
      end else if (s2_adv) begin
         bus.rsp_valid  <= s1_v;
         bus.rsp_id     <= s1_id;
         bus.rsp_result <= {prod_im, prod_re};
      end
   end
endmodule

// File: doc/cmul_scheduler.md
# cmul_scheduler

Round-robin scheduler that shares one pipelined complex multiplier among `NUM_REQ` requesters. Each requester offers a packed complex operand pair over a valid/ready handshake. The block grants at most one request per cycle, tags the request with the requester index, multiplies the pair, and returns the tagged product on a single backpressured response port. It sits between the per-channel datapath engines and the shared arithmetic resource.

## Interface
- `WIDTH`, 32: packed complex width; imag in `[WIDTH-1:WIDTH/2]`, real in `[WIDTH/2-1:0]`, both signed two's complement; even, ≥4
- `NUM_REQ`, 4: number of requesters, ≥2
- `ID_W`, derived: `max(1, clog2(NUM_REQ))`
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `req_valid` in `NUM_REQ`: request valid, one bit per requester
- `req_ready` out `NUM_REQ`: request accepted this cycle; one-hot or zero
- `req_a` in `NUM_REQ*WIDTH`: operand a; requester i at `[i*WIDTH +: WIDTH]`
- `req_b` in `NUM_REQ*WIDTH`: operand b, same packing
- `req_conj` in `NUM_REQ`: conjugate b; present only with `CMUL_SCHED_CONJ_EN`
- `rsp_valid` out 1: response valid
- `rsp_ready` in 1: response consumer ready
- `rsp_id` out `ID_W`: index of the originating requester
- `rsp_result` out `2*WIDTH`: imag in `[2W-1:W]`, real in `[W-1:0]`

## Operation
- Arithmetic: H=`WIDTH/2`. Sign-extend ar, ai, br, bi from H to `WIDTH` bits.
  - real = (ar·br − ai·bi) mod 2^WIDTH
  - imag = (ar·bi + ai·br) mod 2^WIDTH
  - Truncation is silent; no saturation and no overflow flag.
- Pipeline: S1 is the operand register (a, b, id, s1_v). S2 is the output register (result, id, rsp_valid).
- Stall rule:
  - `s2_adv = !rsp_valid || rsp_ready`
  - `s1_adv = !s1_v || s2_adv`
  - S2 loads the S1 product when `s2_adv`. `rsp_valid` takes `s1_v`.
  - S1 loads the granted request when `s1_adv`. `s1_v` takes "any grant".
- Arbiter:
  - `ptr` (`ID_W` bits) holds the index of highest priority.
  - The grant is the first i with `req_valid[i]=1`, scanning ptr, ptr+1, …, NUM_REQ−1, 0, … (wrap).
  - `req_ready[i] = grant[i] && s1_adv`, combinational.
  - On a handshake with requester g, `ptr` becomes (g+1) mod NUM_REQ; otherwise `ptr` holds.
- Requesters hold valid and data stable until ready. While stalled, the grant may move to another requester; only accepted transfers advance `ptr`.
- Fairness: a continuously valid requester is accepted within `NUM_REQ` handshakes.
- Reset mid-operation: in-flight S1/S2 contents are discarded, with no response emitted.

## Timing
- Reset values: `rsp_valid`=0, `rsp_id`=0, `rsp_result`=0, `s1_v`=0, `ptr`=0. `req_ready`=0 while `rst_n`=0.
- Latency: handshake at edge E0 → `rsp_valid`=1 after E0+1 with the result. Two edges total.
- Throughput: 1 result per cycle with `rsp_ready` held high.
- Backpressure: `rsp_valid`, `rsp_id` and `rsp_result` hold stable until `rsp_ready`.
  - Full (S1 and S2 both valid, `rsp_ready`=0): all `req_ready`=0.
  - The response handshake and a new acceptance may happen in the same cycle.
- Empty: with all `req_valid`=0, `ptr` does not move and `s1_v` clears on the next `s1_adv`.
- No combinational path from `req_*` to `rsp_*`. `rsp_ready` reaches `req_ready` combinationally.

## Configuration
- `CMUL_SCHED_CONJ_EN` defined:
  - The `req_conj` port exists and its bit is captured into S1 with the operands.
  - When set, the multiplier uses −bi in place of bi: (a·conj(b)), computed on sign-extended values, so bi=−2^(H−1) is exact.
- Not defined:
  - There is no `req_conj` port and no conj register.
  - Behaviour is the plain product a·b.

## Test plan
- **Single request:** `WIDTH`=32, requester 2, a=0x00040003 (3+4j), b=0x00020001 (1+2j). Expected: 2 edges later `rsp_valid`=1, `rsp_id`=2, `rsp_result`=0x0000000A_FFFFFFFB (−5+10j).
- **Conjugate** (`CMUL_SCHED_CONJ_EN`): same operands with `req_conj[2]`=1. Expected: `rsp_result`=0xFFFFFFFE_0000000B (11−2j).
- **Corner operands:**
  - a=b=0x00008000. Expected: `rsp_result`=0x00000000_40000000.
  - a=b=0x80000000. Expected: `rsp_result`=0x00000000_C0000000.
- **Fairness:** all 4 requesters valid continuously with `rsp_ready`=1. Expected: accept order 0,1,2,3,0,…, one response per cycle with `rsp_id` matching.
- **Backpressure:** hold `rsp_ready`=0 for 5 cycles with 3 requests pending. Expected: exactly 2 accepted (S1 and S2 fill), then all `req_ready`=0. Response stays stable and nothing is lost or duplicated after release.
- **Reset mid-operation:** drop `rst_n` with S1 and S2 valid. Expected: `rsp_valid`=0 immediately and `ptr`=0. After release, the first grant goes to the lowest valid index.
